// File: rtl/pop_expand.sv
// Count-to-thermometer serialiser: an accepted count k becomes a W-bit frame
// with bits 0..k-1 set, sent LSB first. Optional macro: POP_EXPAND_CLAMP_EN.
module pop_expand #(
  parameter int W = 16,
  localparam int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] in_count,
  output logic          in_ready,
  output logic          out_valid,
  output logic          out_bit,
  output logic          out_last,
  input  logic          out_ready,
  output logic          err,
  output logic [7:0]    frames
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] idx_reg, idx_next;
  logic [CW-1:0] k_reg, k_next;
  logic [7:0]    frames_reg, frames_next;
  logic          err_reg, err_next;
  logic          armed_reg;

  logic          fire;
  logic          accept;
  logic          too_big;
  logic          reject;
  logic [CW-1:0] load_k;

  assign out_valid = (state_reg == SHIFT);
  assign out_bit   = out_valid && (idx_reg < k_reg);
  assign out_last  = out_valid && (idx_reg == CW'(W - 1));
  assign fire      = out_valid && out_ready;
  assign in_ready  = (state_reg == IDLE) || (fire && out_last);
  // armed_reg blocks acceptance on the edge that coincides with reset release
  assign accept    = in_valid && in_ready && armed_reg;
  assign too_big   = (in_count > CW'(W));
  assign err       = err_reg;
  assign frames    = frames_reg;

`ifdef POP_EXPAND_CLAMP_EN
  assign load_k = too_big ? CW'(W) : in_count;
  assign reject = 1'b0;
`else
  assign load_k = in_count;
  assign reject = too_big;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      k_reg      <= '0;
      frames_reg <= '0;
      err_reg    <= 1'b0;
      armed_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      k_reg      <= k_next;
      frames_reg <= frames_next;
      err_reg    <= err_next;
      armed_reg  <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    k_next      = k_reg;
    frames_next = frames_reg;
    err_next    = 1'b0;

    if (fire) begin
      if (out_last) begin
        frames_next = frames_reg + 8'd1;
        state_next  = IDLE;
      end else begin
        idx_next = idx_reg + CW'(1);
      end
    end

    // a same-cycle accept overrides the return to IDLE, giving back-to-back frames
    if (accept) begin
      if (reject) begin
        err_next = 1'b1;
      end else begin
        k_next     = load_k;
        idx_next   = '0;
        state_next = SHIFT;
      end
    end
  end

endmodule

// File: tb/tb_pop_expand.sv
// Directed bench for pop_expand (W=16): frame contents, stalls, back-to-back,
// illegal counts, mid-frame reset and frame counter wrap.
module tb_pop_expand;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] in_count;
  logic       in_ready;
  logic       out_valid;
  logic       out_bit;
  logic       out_last;
  logic       out_ready;
  logic       err;
  logic [7:0] frames;

  int tests = 0;
  int fails = 0;

  pop_expand #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .out_ready (out_ready),
    .err       (err),
    .frames    (frames)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // present k for one rising edge; starts and ends at a falling edge
  task automatic send(input logic [4:0] k);
    in_valid = 1'b1;
    in_count = k;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input bit toggle, input bit drop_valid,
                      output logic [15:0] bits, output logic [15:0] lasts,
                      output int wait_cyc, output int span, output int holdbad);
    int   idx;
    bit   rdy;
    bit   stalled;
    logic pb, pl;
    bits = '0; lasts = '0; wait_cyc = 0; span = 0; holdbad = 0;
    idx = 0; stalled = 1'b0; pb = 1'b0; pl = 1'b0;
    while (!out_valid && wait_cyc < 40) begin
      @(negedge clk);
      wait_cyc++;
    end
    while (idx < 16 && span < 100) begin
      rdy = toggle ? ((span % 2) == 0) : 1'b1;
      out_ready = rdy;
      if (drop_valid && span == 0) in_valid = 1'b0;
      if (out_valid) begin
        if (stalled && (out_bit !== pb || out_last !== pl)) holdbad++;
        if (rdy) begin
          bits[idx]  = out_bit;
          lasts[idx] = out_last;
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pb = out_bit;
          pl = out_last;
        end
      end
      span++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (idx != 16) check("frame_timeout", idx, 16);
  endtask

  logic [15:0] b, l, e;
  int w, s, h, bad, exp_frames;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {out_valid, out_bit, out_last, err, in_ready}, 5'b00001);
    check("rst_frames", frames, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    exp_frames = 0;

    send(5'd5);
    recv(1'b0, 1'b0, b, l, w, s, h);
    exp_frames++;
    check("k5_latency", w, 0);
    check("k5_bits", b, 16'h001F);
    check("k5_last", l, 16'h8000);
    check("k5_span", s, 16);
    check("k5_frames", frames, 1);

    send(5'd0);
    recv(1'b0, 1'b0, b, l, w, s, h);
    exp_frames++;
    check("k0_bits", b, 16'h0000);
    check("k0_last", l, 16'h8000);

    send(5'd16);
    recv(1'b0, 1'b0, b, l, w, s, h);
    exp_frames++;
    check("k16_bits", b, 16'hFFFF);
    check("k16_last", l, 16'h8000);
    check("k16_frames", frames, 3);

    // ready alternates starting high: 16 bits take 31 cycles, idle on the 32nd
    send(5'd9);
    recv(1'b1, 1'b0, b, l, w, s, h);
    exp_frames++;
    check("k9_bits", b, 16'h01FF);
    check("k9_hold", h, 0);
    check("k9_span", s, 31);
    check("k9_idle", out_valid, 0);
    check("k9_frames", frames, 4);

    in_valid = 1'b1;
    in_count = 5'd3;
    @(negedge clk);
    in_count = 5'd12;
    recv(1'b0, 1'b0, b, l, w, s, h);
    check("b2b_bits1", b, 16'h0007);
    recv(1'b0, 1'b1, b, l, w, s, h);
    exp_frames += 2;
    check("b2b_gap", w, 0);
    check("b2b_bits2", b, 16'h0FFF);
    check("b2b_frames", frames, 6);

    send(5'd20);
`ifdef POP_EXPAND_CLAMP_EN
    check("k20_err", err, 0);
    recv(1'b0, 1'b0, b, l, w, s, h);
    exp_frames++;
    check("k20_bits", b, 16'hFFFF);
    check("k20_err_after", err, 0);
`else
    check("k20_err", err, 1);
    check("k20_valid", out_valid, 0);
    @(negedge clk);
    check("k20_pulse", err, 0);
    check("k20_valid2", out_valid, 0);
`endif
    check("k20_frames", frames, exp_frames);

    send(5'd10);
    repeat (7) @(negedge clk);
    check("rst_bit7", {out_valid, out_bit, out_last}, 3'b110);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {out_valid, out_bit, out_last, err, in_ready}, 5'b00001);
    check("midrst_frames", frames, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    bad = 0;
    for (int i = 0; i < 256; i++) begin
      send(5'(i % 17));
      recv(1'b0, 1'b0, b, l, w, s, h);
      e = 16'((32'd1 << (i % 17)) - 32'd1);
      if (b !== e || l !== 16'h8000) bad++;
      if (i == 254) check("wrap_255", frames, 255);
    end
    check("wrap_bad_frames", bad, 0);
    check("wrap_0", frames, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
